l1_cache_control: RTL and testbench

Sequencing controller for the 2-way, 8-set L1 cache built from two `L1_cache_way` instances.
- Decides hit or miss per CPU request and drives each way's 4-bit `array_write` strobes (`{dirty, valid, tag, data}`).
- Tracks per-set LRU internally.
- Runs writeback and fill transactions against physical memory through a request/response handshake.
- Sits between the CPU memory port and the L2/physical memory interface; the cache datapath (ways, muxes, comparators) is external.

---
 rtl/l1_cache_control.sv | 132 +++++++++++++
 tb/tb_l1_cache_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache_control.sv
// Hit/miss sequencing for a 2-way, 8-set L1 cache: per-set LRU, victim
// writeback and line fill against physical memory, way array write strobes.
module l1_cache_control #(
  parameter int unsigned SETS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [$clog2(SETS)-1:0] index,
  input  logic                    hit0,
  input  logic                    hit1,
  input  logic                    valid0,
  input  logic                    valid1,
  input  logic                    dirty0,
  input  logic                    dirty1,
  input  logic                    pmem_resp,
  output logic                    mem_resp,
  output logic [3:0]              way0_write,
  output logic [3:0]              way1_write,
  output logic                    dirty_in,
  output logic                    data_sel,
  output logic                    out_way,
  output logic                    pmem_addr_sel,
  output logic                    pmem_read,
  output logic                    pmem_write
);

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } state_t;

  localparam logic [3:0] STRB_HIT_WR = 4'b1001;
  localparam logic [3:0] STRB_FILL   = 4'b1111;

  state_t          r_state;
  state_t          w_next;
  logic [SETS-1:0] r_lru;
  logic            r_victim;

  logic            w_req;
  logic            w_hit;
  logic            w_hit_way;
  logic            w_lru_way;
  logic            w_victim_dirty;
  logic [3:0]      w_strobe;
  logic            w_strobe_way;

  assign w_req          = mem_read | mem_write;
  assign w_hit          = hit0 | hit1;
  // A double hit resolves to way 0.
  assign w_hit_way      = ~hit0;
  assign w_lru_way      = r_lru[index];
  assign w_victim_dirty = w_lru_way ? (valid1 & dirty1) : (valid0 & dirty0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= CHECK;
      r_lru    <= '0;
      r_victim <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == CHECK && w_req) begin
        if (w_hit) begin
          r_lru[index] <= ~w_hit_way;
        end else begin
          r_victim <= w_lru_way;
        end
      end
    end
  end

  // Outputs are forced low while reset is sampled so no array write or
  // pmem request escapes during the reset cycle.
  always_comb begin
    w_next        = r_state;
    w_strobe      = '0;
    w_strobe_way  = 1'b0;
    mem_resp      = 1'b0;
    dirty_in      = 1'b0;
    data_sel      = 1'b0;
    out_way       = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    if (reset_n) begin
      case (r_state)
        CHECK: begin
          if (w_req) begin
            if (w_hit) begin
              mem_resp = 1'b1;
              out_way  = w_hit_way;
              if (mem_write) begin
                w_strobe     = STRB_HIT_WR;
                w_strobe_way = w_hit_way;
                dirty_in     = 1'b1;
              end
            end else begin
              out_way = w_lru_way;
              w_next  = w_victim_dirty ? WRITEBACK : FILL;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          out_way       = r_victim;
          if (pmem_resp) begin
            w_next = FILL;
          end
        end
        FILL: begin
          pmem_read = 1'b1;
          out_way   = r_victim;
          if (pmem_resp) begin
            w_strobe     = STRB_FILL;
            w_strobe_way = r_victim;
            data_sel     = 1'b1;
            w_next       = CHECK;
          end
        end
        default: w_next = CHECK;
      endcase
    end
  end

  assign way0_write = w_strobe_way ? 4'b0000 : w_strobe;
  assign way1_write = w_strobe_way ? w_strobe : 4'b0000;

endmodule

// File: tb/tb_l1_cache_control.sv
// Self-checking bench for l1_cache_control: directed scenarios then random
// per-cycle stimulus, all checked against a transaction-level cache model.
module tb_l1_cache_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mem_read = 1'b0;
  logic       mem_write = 1'b0;
  logic [2:0] index = '0;
  logic       hit0 = 1'b0;
  logic       hit1 = 1'b0;
  logic       valid0 = 1'b0;
  logic       valid1 = 1'b0;
  logic       dirty0 = 1'b0;
  logic       dirty1 = 1'b0;
  logic       pmem_resp = 1'b0;
  logic       mem_resp;
  logic [3:0] way0_write;
  logic [3:0] way1_write;
  logic       dirty_in;
  logic       data_sel;
  logic       out_way;
  logic       pmem_addr_sel;
  logic       pmem_read;
  logic       pmem_write;

  l1_cache_control #(.SETS(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .index         (index),
    .hit0          (hit0),
    .hit1          (hit1),
    .valid0        (valid0),
    .valid1        (valid1),
    .dirty0        (dirty0),
    .dirty1        (dirty1),
    .pmem_resp     (pmem_resp),
    .mem_resp      (mem_resp),
    .way0_write    (way0_write),
    .way1_write    (way1_write),
    .dirty_in      (dirty_in),
    .data_sel      (data_sel),
    .out_way       (out_way),
    .pmem_addr_sel (pmem_addr_sel),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] STRB_DATA  = 4'b0001;
  localparam logic [3:0] STRB_TAG   = 4'b0010;
  localparam logic [3:0] STRB_VALID = 4'b0100;
  localparam logic [3:0] STRB_DIRTY = 4'b1000;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc_no   = 0;

  // Reference model: a miss is "outstanding" with a list of pending pmem
  // transactions; each pmem_resp retires the head of that list.
  bit m_lru [8];
  bit m_victim;
  int m_pending_wb;
  int m_pending_fill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h cycle %0d", tag, got, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_lru[i] = 1'b0;
    m_victim       = 1'b0;
    m_pending_wb   = 0;
    m_pending_fill = 0;
  endtask

  task automatic tick();
    logic       e_resp, e_din, e_dsel, e_oway, e_asel, e_pr, e_pw, oway_care;
    logic       req, way;
    logic [3:0] e_w0, e_w1;
    @(negedge clk);
    e_resp = 1'b0; e_din = 1'b0; e_dsel = 1'b0; e_oway = 1'b0;
    e_asel = 1'b0; e_pr = 1'b0; e_pw = 1'b0; oway_care = 1'b1;
    e_w0 = '0; e_w1 = '0;
    req = mem_read | mem_write;
    way = 1'b0;
    if (reset_n) begin
      if (m_pending_wb > 0) begin
        e_pw = 1'b1; e_asel = 1'b1; e_oway = m_victim;
      end else if (m_pending_fill > 0) begin
        e_pr = 1'b1; oway_care = 1'b0;
        if (pmem_resp) begin
          e_dsel = 1'b1;
          if (m_victim) e_w1 = STRB_DATA | STRB_TAG | STRB_VALID | STRB_DIRTY;
          else          e_w0 = STRB_DATA | STRB_TAG | STRB_VALID | STRB_DIRTY;
        end
      end else if (req) begin
        if (hit0 || hit1) begin
          way = hit0 ? 1'b0 : 1'b1;
          e_resp = 1'b1; e_oway = way;
          if (mem_write) begin
            e_din = 1'b1;
            if (way) e_w1 = STRB_DATA | STRB_DIRTY;
            else     e_w0 = STRB_DATA | STRB_DIRTY;
          end
        end else begin
          e_oway = m_lru[index];
        end
      end
    end
    check("mem_resp",      {31'b0, mem_resp},      {31'b0, e_resp});
    check("way0_write",    {28'b0, way0_write},    {28'b0, e_w0});
    check("way1_write",    {28'b0, way1_write},    {28'b0, e_w1});
    check("dirty_in",      {31'b0, dirty_in},      {31'b0, e_din});
    check("data_sel",      {31'b0, data_sel},      {31'b0, e_dsel});
    check("pmem_addr_sel", {31'b0, pmem_addr_sel}, {31'b0, e_asel});
    check("pmem_read",     {31'b0, pmem_read},     {31'b0, e_pr});
    check("pmem_write",    {31'b0, pmem_write},    {31'b0, e_pw});
    check("pmem_excl",     {31'b0, pmem_read & pmem_write}, 32'd0);
    if (oway_care) check("out_way", {31'b0, out_way}, {31'b0, e_oway});
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else if (m_pending_wb > 0) begin
      if (pmem_resp) m_pending_wb--;
    end else if (m_pending_fill > 0) begin
      if (pmem_resp) m_pending_fill--;
    end else if (req) begin
      if (hit0 || hit1) begin
        m_lru[index] = ~way;
      end else begin
        m_victim       = m_lru[index];
        m_pending_fill = 1;
        m_pending_wb   = (m_victim ? (valid1 && dirty1) : (valid0 && dirty0)) ? 1 : 0;
      end
    end
    cyc_no++;
    #1;
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [2:0] idx,
                     input logic h0, input logic h1, input logic v0, input logic v1,
                     input logic d0, input logic d1, input logic pr);
    mem_read = rd; mem_write = wr; index = idx;
    hit0 = h0; hit1 = h1; valid0 = v0; valid1 = v1;
    dirty0 = d0; dirty1 = d1; pmem_resp = pr;
    tick();
  endtask

  initial begin
    model_reset();
    #1;
    reset_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // read hit way 0, set 3
    cyc(1, 0, 3, 1, 0, 1, 0, 0, 0, 0);
    // write hit way 1, set 5
    cyc(0, 1, 5, 0, 1, 0, 1, 0, 0, 0);

    // clean read miss, set 2, fill held 4 cycles, then hit
    cyc(1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 2, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 2, 1, 0, 1, 0, 0, 0, 0);

    // set 7: hit way 0 so way 1 is LRU, then dirty miss on way 1
    cyc(1, 0, 7, 1, 0, 1, 1, 0, 1, 0);
    cyc(1, 0, 7, 0, 0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) cyc(1, 0, 7, 0, 0, 1, 1, 0, 1, 0);
    cyc(1, 0, 7, 0, 0, 1, 1, 0, 1, 1);
    cyc(1, 0, 7, 0, 0, 1, 1, 0, 1, 0);
    cyc(1, 0, 7, 0, 0, 1, 1, 0, 1, 1);
    cyc(1, 0, 7, 0, 1, 1, 1, 0, 0, 0);

    // reset during fill, then set 3 (LRU was way 1) misses to way 0
    cyc(1, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    cyc(1, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    cyc(0, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 3, 0, 0, 1, 1, 1, 1, 0);
    cyc(1, 0, 3, 0, 0, 1, 1, 1, 1, 1);
    cyc(1, 0, 3, 0, 0, 1, 1, 1, 1, 0);
    cyc(1, 0, 3, 0, 0, 1, 1, 1, 1, 1);
    cyc(1, 0, 3, 1, 0, 1, 1, 0, 1, 0);

    // double hit on write: way 0 wins; read+write treated as write
    cyc(0, 1, 6, 1, 1, 1, 1, 0, 0, 0);
    cyc(1, 1, 6, 0, 1, 1, 1, 0, 0, 0);

    // request dropped mid-miss
    cyc(0, 1, 1, 0, 0, 1, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      logic h0, h1;
      reset_n = ($urandom_range(0, 149) != 0);
      h0 = ($urandom_range(0, 2) == 0);
      h1 = ($urandom_range(0, 2) == 0);
      if (h0 && h1 && $urandom_range(0, 7) != 0) h1 = 1'b0;
      cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0),
          3'($urandom_range(0, 7)), h0, h1,
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
